// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve multiplies with one combinational 33x33 multiply instead.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [4:0] OP_MUL    = 5'b10010;
    localparam logic [4:0] OP_MULH   = 5'b10011;
    localparam logic [4:0] OP_MULHSU = 5'b10100;
    localparam logic [4:0] OP_MULHU  = 5'b10101;
    localparam logic [4:0] OP_DIV    = 5'b10110;
    localparam logic [4:0] OP_DIVU   = 5'b10111;
    localparam logic [4:0] OP_REM    = 5'b11000;
    localparam logic [4:0] OP_REMU   = 5'b11001;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_count;
    logic [4:0]      r_op;
    logic            r_neg;
    logic            r_a_neg;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_result;

    logic            w_valid, w_is_div, w_sgn_a, w_sgn_b, w_a_neg, w_b_neg;
    logic            w_div0, w_ovf, w_early;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_early_res;
    logic            w_r_is_div;

    assign w_valid  = (op >= OP_MUL) && (op <= OP_REMU);
    assign w_is_div = (op >= OP_DIV);
    assign w_sgn_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_sgn_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg  = w_sgn_a & a[XLEN-1];
    assign w_b_neg  = w_sgn_b & b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    assign w_div0   = w_is_div && (b == '0);
    assign w_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN:0]   w_a33x, w_b33x;
    logic [2*XLEN-1:0] w_fprod;
    assign w_a33x  = {{(XLEN+1){w_a_neg}}, a};
    assign w_b33x  = {{(XLEN+1){w_b_neg}}, b};
    assign w_fprod = w_a33x[2*XLEN-1:0] * w_b33x[2*XLEN-1:0];
    assign w_early = w_div0 | w_ovf | ~w_is_div;
`else
    assign w_early = w_div0 | w_ovf;
`endif

    always_comb begin
        w_early_res = '0;
        if (w_div0) begin
            w_early_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
        end else if (w_ovf) begin
            w_early_res = (op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!w_is_div) begin
            w_early_res = (op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One restoring-divide step: shift in the next dividend bit, subtract when it fits.
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN:0]   w_sum;
    assign w_r_is_div = (r_op >= OP_DIV);
    assign w_shift    = {r_hi, r_lo[XLEN-1]};
    assign w_ge       = (w_shift >= {1'b0, r_opnd});
    assign w_diff     = w_shift[XLEN-1:0] - r_opnd;
    assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
    assign w_prod_s = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
    assign w_quo    = r_neg ? (~r_lo + 1'b1) : r_lo;
    assign w_rem    = r_a_neg ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        case (r_op)
            OP_MUL:                        w_fix_res = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo;
            default:                       w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_a_neg  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_valid && !flush) begin
                        if (w_early) begin
                            r_state  <= S_DONE;
                            r_result <= w_early_res;
                        end else begin
                            r_state <= S_CALC;
                            r_count <= '0;
                            r_op    <= op;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_a_neg <= w_a_neg;
                            r_hi    <= '0;
                            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                            r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_r_is_div) begin
                            r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == '1) r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state  <= S_DONE;
                        r_result <= w_fix_res;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign stall  = ((r_state == S_IDLE) && start && w_valid && !flush) ||
                    (r_state == S_CALC) || (r_state == S_FIXUP);
    assign done   = (r_state == S_DONE) && !flush;
    assign result = r_result;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, random ops against an arithmetic model, aborts.
module tb_muldiv_seq;
    localparam logic [4:0] OP_MUL    = 5'b10010;
    localparam logic [4:0] OP_MULH   = 5'b10011;
    localparam logic [4:0] OP_MULHSU = 5'b10100;
    localparam logic [4:0] OP_MULHU  = 5'b10101;
    localparam logic [4:0] OP_DIV    = 5'b10110;
    localparam logic [4:0] OP_DIVU   = 5'b10111;
    localparam logic [4:0] OP_REM    = 5'b11000;
    localparam logic [4:0] OP_REMU   = 5'b11001;

    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy, stall, done;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exp = 32'h0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        int ix, iy;
        sx = longint'({{32{x[31]}}, x});
        sy = longint'({{32{y[31]}}, y});
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        ix = int'(x);
        iy = int'(y);
        case (o)
            OP_MUL:    begin p = sx * sy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV:    begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ix / iy);
            end
            OP_DIVU:   return (y == 0) ? 32'hFFFFFFFF : x / y;
            OP_REM:    begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        bit is_div;
        is_div = (o >= OP_DIV);
        if (is_div && y == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) return 1;
`endif
        return 34;
    endfunction

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
        int k;
        int exp_lat;
        bit got;
        bit stall_ok;
        logic [31:0] exp;
        logic stall_done;
        exp = model(o, x, y);
        exp_lat = lat_of(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL stall_c0 op=%b got=%b want=1", o, stall);
        end
        k = 0; got = 0; stall_ok = 1; stall_done = 1'bx;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (hold) begin
                op = OP_DIVU; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1;
                stall_done = stall;
            end else if (stall !== 1'b1) begin
                stall_ok = 0;
            end
        end
        start = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL timeout op=%b a=%h b=%h got=no_done want=done", o, x, y);
        end else begin
            if (k != exp_lat) begin
                bad++;
                $display("FAIL latency op=%b a=%h b=%h got=%0d want=%0d", o, x, y, k, exp_lat);
            end
            total++;
            if (result !== exp) begin
                bad++;
                $display("FAIL result op=%b a=%h b=%h got=%h want=%h", o, x, y, result, exp);
            end
            total++;
            if (stall_done !== 1'b0 || !stall_ok) begin
                bad++;
                $display("FAIL stall_seq op=%b got_done_stall=%b busy_cycles_ok=%0d want=0/1", o, stall_done, stall_ok);
            end
            last_exp = exp;
        end
        $display("txn op=%b a=%h b=%h result=%h expect=%h cycles=%0d", o, x, y, result, exp, k);
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL post_idle op=%b got busy=%b done=%b want 0/0", o, busy, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = 5'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, stall, done, result} !== 35'h0) begin
            bad++;
            $display("FAIL reset_hold got=%b%b%b %h want=000 00000000", busy, stall, done, result);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, stall, done, result} !== 35'h0) begin
            bad++;
            $display("FAIL reset_release got=%b%b%b %h want=000 00000000", busy, stall, done, result);
        end
        $display("txn reset busy=%b stall=%b done=%b result=%h", busy, stall, done, result);
    endtask

    task automatic test_directed();
        run_op(OP_DIV,    32'hFFFFFFF9, 32'h2, 0);
        run_op(OP_REM,    32'hFFFFFFF9, 32'h2, 0);
        run_op(OP_DIVU,   32'hFFFFFFFF, 32'h2, 0);
        run_op(OP_REMU,   32'hFFFFFFFF, 32'h2, 0);
        run_op(OP_DIV,    32'h5, 32'h0, 0);
        run_op(OP_REM,    32'h5, 32'h0, 0);
        run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_MULH,   32'h80000000, 32'h80000000, 0);
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(OP_MUL,    32'h3, 32'hFFFFFFFC, 0);
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(OP_DIVU,   32'h0, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [4:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 30; i++) begin
            o = 5'(OP_MUL + $urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = 32'(32'($urandom_range(1, 15)));
                3: x = -x;
                default: ;
            endcase
            run_op(o, x, y, 0);
        end
    endtask

    task automatic test_start_in_calc();
        run_op(OP_DIV, 32'hDEADBEEF, 32'h00001234, 1);
        run_op(OP_MULHSU, 32'h87654321, 32'hF0000001, 1);
    endtask

    task automatic test_invalid_op();
        logic [4:0] bad_ops [2];
        bad_ops[0] = 5'b00101;
        bad_ops[1] = 5'b11010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            op = bad_ops[i]; a = 32'h9; b = 32'h3; start = 1'b1;
            #1;
            total++;
            if (stall !== 1'b0) begin
                bad++;
                $display("FAIL invalid_stall op=%b got=%b want=0", bad_ops[i], stall);
            end
            @(posedge clk); #1;
            start = 1'b0;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== last_exp) begin
                bad++;
                $display("FAIL invalid_state op=%b got busy=%b done=%b res=%h want 0/0/%h", bad_ops[i], busy, done, result, last_exp);
            end
            $display("txn invalid op=%b busy=%b result=%h", bad_ops[i], busy, result);
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        op = OP_DIV; a = 32'h64; b = 32'h7; start = 1'b1; flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_stall got=%b want=0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_busy got=%b want=0", busy);
        end
        $display("txn flush_idle busy=%b", busy);
    endtask

    task automatic test_flush_calc();
        bit saw_done;
        @(negedge clk);
        op = OP_DIVU; a = 32'h12345678; b = 32'h9; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_calc_idle got busy=%b stall=%b want 0/0", busy, stall);
        end
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1;
        end
        total++;
        if (saw_done || result !== last_exp) begin
            bad++;
            $display("FAIL flush_calc_after got done=%0d res=%h want 0/%h", saw_done, result, last_exp);
        end
        $display("txn flush_calc busy=%b result=%h", busy, result);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = OP_DIV; a = 32'h7FFFFFFF; b = 32'h3; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, stall, done, result} !== 35'h0) begin
            bad++;
            $display("FAIL reset_mid got=%b%b%b %h want=000 00000000", busy, stall, done, result);
        end
        $display("txn reset_mid busy=%b stall=%b result=%h", busy, stall, result);
        last_exp = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_calc();
        test_invalid_op();
        test_flush_idle();
        test_flush_calc();
        test_reset_mid();
        run_op(OP_REMU, 32'h0000FFFF, 32'h00000100, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
